// File: rtl/accelerator_pkg.sv
// Shared types for the APU request/response path: dispatcher FSM states and
// the buffered vector command record.
package accelerator_pkg;

  localparam int APU_OP_W     = 6;
  localparam int APU_NARGS    = 3;
  localparam int APU_WORD_W   = 32;
  localparam int APU_FLAGS_W  = 15;
  localparam int APU_RFLAGS_W = 5;
  localparam int APU_RD_W     = 5;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_RVALID,
    RESP
  } apu_disp_state_t;

  typedef struct packed {
    logic [APU_OP_W-1:0]                     op;
    logic [APU_NARGS-1:0][APU_WORD_W-1:0]    operands;
    logic [APU_FLAGS_W-1:0]                  flags;
    logic [APU_RD_W-1:0]                     rd;
  } apu_cmd_t;

  // Counter width able to hold values 0..n (at least one bit).
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/apu_dispatcher_if.sv
// Signal bundle between the dispatcher (master) and its environment: command
// input, APU request/response and writeback response.
interface apu_dispatcher_if;
  import accelerator_pkg::*;

  // Handshakes: a transfer happens on a rising clock edge where the sender's
  // valid and the receiver's ready are both high (cmd_valid/cmd_ready,
  // apu_req/apu_gnt, rsp_valid/rsp_ready); while valid is high and no
  // transfer has occurred, the sender keeps its payload stable. apu_rvalid is
  // a one-cycle pulse with no back-pressure.
  logic                                  cmd_valid;
  logic                                  cmd_ready;
  logic [APU_OP_W-1:0]                   cmd_op;
  logic [APU_NARGS-1:0][APU_WORD_W-1:0]  cmd_operands;
  logic [APU_FLAGS_W-1:0]                cmd_flags;
  logic [APU_RD_W-1:0]                   cmd_rd;

  logic                                  apu_req;
  logic [APU_NARGS-1:0][APU_WORD_W-1:0]  apu_operands_o;
  logic [APU_OP_W-1:0]                   apu_op_o;
  logic [APU_FLAGS_W-1:0]                apu_flags_o;
  logic                                  apu_gnt;
  logic                                  apu_rvalid;
  logic [APU_WORD_W-1:0]                 apu_result;
  logic [APU_RFLAGS_W-1:0]               apu_flags_i;

  logic                                  rsp_valid;
  logic                                  rsp_ready;
  logic [APU_WORD_W-1:0]                 rsp_result;
  logic [APU_RFLAGS_W-1:0]               rsp_flags;
  logic [APU_RD_W-1:0]                   rsp_rd;
  logic                                  rsp_timeout;
  logic                                  busy;

  modport master (
    input  cmd_valid, cmd_op, cmd_operands, cmd_flags, cmd_rd,
    output cmd_ready,
    output apu_req, apu_operands_o, apu_op_o, apu_flags_o,
    input  apu_gnt, apu_rvalid, apu_result, apu_flags_i,
    output rsp_valid, rsp_result, rsp_flags, rsp_rd, rsp_timeout,
    input  rsp_ready,
    output busy
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_operands, cmd_flags, cmd_rd,
    input  cmd_ready,
    input  apu_req, apu_operands_o, apu_op_o, apu_flags_o,
    output apu_gnt, apu_rvalid, apu_result, apu_flags_i,
    input  rsp_valid, rsp_result, rsp_flags, rsp_rd, rsp_timeout,
    output rsp_ready,
    input  busy
  );

endinterface

// File: rtl/apu_cmd_fifo.sv
// Synchronous FIFO of apu_cmd_t. DEPTH must be a power of two so the
// pointers wrap naturally; occupancy counts 0..DEPTH.
module apu_cmd_fifo
  import accelerator_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     push_i,
  input  apu_cmd_t push_data_i,
  input  logic     pop_i,
  output apu_cmd_t pop_data_o,
  output logic     full_o,
  output logic     empty_o
);

  localparam int PTR_W = (DEPTH < 2) ? 1 : $clog2(DEPTH);
  localparam int CNT_W = cnt_width(DEPTH);

  apu_cmd_t          mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic              push_ok;
  logic              pop_ok;

  assign full_o     = (count_q == CNT_W'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign push_ok    = push_i && !full_o;
  assign pop_ok     = pop_i && !empty_o;
  assign pop_data_o = mem_q[rd_ptr_q];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: entries are only read while counted as valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/apu_dispatcher.sv
// CPU-side APU initiator: buffers commands, issues one request at a time,
// waits for grant and result (with optional timeout) and returns a response.
module apu_dispatcher
  import accelerator_pkg::*;
#(
  parameter int FIFO_DEPTH     = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic             clk,
  input  logic             reset,
  apu_dispatcher_if.master bus,
  output apu_disp_state_t  state_o
);

  localparam bit TMO_EN = (TIMEOUT_CYCLES != 0);
  localparam int TMO_W  = cnt_width(TIMEOUT_CYCLES);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_EN ? TIMEOUT_CYCLES - 1 : 0);

  apu_disp_state_t          state_q;
  apu_cmd_t                 req_q;
  logic                     apu_req_q;
  logic                     rsp_valid_q;
  logic [APU_WORD_W-1:0]    rsp_result_q;
  logic [APU_RFLAGS_W-1:0]  rsp_flags_q;
  logic [APU_RD_W-1:0]      rsp_rd_q;
  logic                     rsp_timeout_q;
  logic [TMO_W-1:0]         tmo_q;

  apu_cmd_t fifo_head;
  apu_cmd_t fifo_in;
  logic     fifo_full;
  logic     fifo_empty;
  logic     fifo_pop;

  assign fifo_in.op       = bus.cmd_op;
  assign fifo_in.operands = bus.cmd_operands;
  assign fifo_in.flags    = bus.cmd_flags;
  assign fifo_in.rd       = bus.cmd_rd;
  assign fifo_pop         = (state_q == IDLE) && !fifo_empty;

  apu_cmd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (bus.cmd_valid),
    .push_data_i (fifo_in),
    .pop_i       (fifo_pop),
    .pop_data_o  (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  // tmo_q counts completed WAIT_RVALID cycles; a result on the last allowed
  // cycle still beats the timeout.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      req_q         <= '0;
      apu_req_q     <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_result_q  <= '0;
      rsp_flags_q   <= '0;
      rsp_rd_q      <= '0;
      rsp_timeout_q <= 1'b0;
      tmo_q         <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            req_q     <= fifo_head;
            apu_req_q <= 1'b1;
            state_q   <= REQ;
          end
        end
        REQ: begin
          if (bus.apu_gnt) begin
            apu_req_q <= 1'b0;
            if (bus.apu_rvalid) begin
              rsp_result_q  <= bus.apu_result;
              rsp_flags_q   <= bus.apu_flags_i;
              rsp_rd_q      <= req_q.rd;
              rsp_timeout_q <= 1'b0;
              rsp_valid_q   <= 1'b1;
              state_q       <= RESP;
            end else begin
              tmo_q   <= '0;
              state_q <= WAIT_RVALID;
            end
          end
        end
        WAIT_RVALID: begin
          if (bus.apu_rvalid) begin
            rsp_result_q  <= bus.apu_result;
            rsp_flags_q   <= bus.apu_flags_i;
            rsp_rd_q      <= req_q.rd;
            rsp_timeout_q <= 1'b0;
            rsp_valid_q   <= 1'b1;
            state_q       <= RESP;
          end else if (TMO_EN && (tmo_q == TMO_LAST)) begin
            rsp_result_q  <= '0;
            rsp_flags_q   <= '0;
            rsp_rd_q      <= req_q.rd;
            rsp_timeout_q <= 1'b1;
            rsp_valid_q   <= 1'b1;
            state_q       <= RESP;
          end else begin
            tmo_q <= tmo_q + TMO_W'(1);
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready      = !fifo_full;
  assign bus.apu_req        = apu_req_q;
  assign bus.apu_operands_o = req_q.operands;
  assign bus.apu_op_o       = req_q.op;
  assign bus.apu_flags_o    = req_q.flags;
  assign bus.rsp_valid      = rsp_valid_q;
  assign bus.rsp_result     = rsp_result_q;
  assign bus.rsp_flags      = rsp_flags_q;
  assign bus.rsp_rd         = rsp_rd_q;
  assign bus.rsp_timeout    = rsp_timeout_q;
  assign bus.busy           = (state_q != IDLE) || !fifo_empty;
  assign state_o            = state_q;

endmodule

// File: tb/tb_apu_dispatcher.sv
// Bench for apu_dispatcher: directed scenarios plus randomized traffic, with a
// scripted accelerator responder and an in-order response scoreboard.
module tb_apu_dispatcher;
  import accelerator_pkg::*;

  localparam int TMO   = 8;
  localparam int EXP_W = 1 + APU_RD_W + APU_RFLAGS_W + APU_WORD_W;

  // How the accelerator treats one request: grant delay in cycles, result
  // delay in cycles after the grant (0 = with the grant), result payload.
  typedef struct {
    int                       gnt_dly;
    int                       rv_dly;
    logic [APU_WORD_W-1:0]    res;
    logic [APU_RFLAGS_W-1:0]  rfl;
  } plan_t;

  // ---------------- clock / reset ----------------
  logic            clk = 1'b0;
  logic            reset = 1'b1;
  apu_disp_state_t state;

  always #5 clk = ~clk;

  apu_dispatcher_if bus ();

  apu_dispatcher #(
    .FIFO_DEPTH     (2),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus.master),
    .state_o (state)
  );

  // ---------------- scoreboard state ----------------
  int              n_checks = 0;
  int              n_pass   = 0;
  int              n_rsp    = 0;
  int              rdy_mode = 1;
  logic [EXP_W-1:0] exp_q[$];
  apu_cmd_t        req_q[$];
  plan_t           plan_q[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: the response carries the accelerator's result if it
  // arrives within TMO cycles of the grant, otherwise a zeroed timeout.
  function automatic logic [EXP_W-1:0] expect_rsp(input apu_cmd_t c, input plan_t p);
    if (p.rv_dly > TMO) return {1'b1, c.rd, 5'd0, 32'd0};
    return {1'b0, c.rd, p.rfl, p.res};
  endfunction

  function automatic apu_cmd_t rand_cmd(input logic [4:0] rd);
    apu_cmd_t c;
    c.op          = 6'($urandom);
    c.operands[0] = $urandom;
    c.operands[1] = $urandom;
    c.operands[2] = $urandom;
    c.flags       = 15'($urandom);
    c.rd          = rd;
    return c;
  endfunction

  function automatic plan_t mk_plan(input int g, input int r);
    plan_t p;
    p.gnt_dly = g;
    p.rv_dly  = r;
    p.res     = $urandom;
    p.rfl     = 5'($urandom);
    return p;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic push_cmd(input apu_cmd_t c, input plan_t p, output int waited);
    waited           = 0;
    bus.cmd_op       = c.op;
    bus.cmd_operands = c.operands;
    bus.cmd_flags    = c.flags;
    bus.cmd_rd       = c.rd;
    bus.cmd_valid    = 1'b1;
    while (!bus.cmd_ready) begin
      @(negedge clk);
      waited++;
      if (waited > 300) begin
        chk("push_timeout", waited, 0);
        bus.cmd_valid = 1'b0;
        return;
      end
    end
    exp_q.push_back(expect_rsp(c, p));
    req_q.push_back(c);
    plan_q.push_back(p);
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp_valid(input string name);
    int k = 0;
    while (!bus.rsp_valid && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk(name, bus.rsp_valid, 1);
  endtask

  task automatic drain();
    int k = 0;
    while ((exp_q.size() != 0 || bus.busy) && k < 3000) begin
      @(negedge clk);
      k++;
    end
    chk("drain_empty", exp_q.size(), 0);
    chk("drain_idle", bus.busy, 0);
  endtask

  // rsp_ready changes just after the active edge.
  initial begin
    bus.rsp_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       bus.rsp_ready = 1'b0;
        1:       bus.rsp_ready = 1'b1;
        default: bus.rsp_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // ---------------- accelerator responder ----------------
  initial begin
    plan_t    p;
    apu_cmd_t c;
    bus.apu_gnt     = 1'b0;
    bus.apu_rvalid  = 1'b0;
    bus.apu_result  = '0;
    bus.apu_flags_i = '0;
    forever begin
      @(negedge clk);
      if (!reset && bus.apu_req) begin
        if (plan_q.size() == 0 || req_q.size() == 0) begin
          chk("req_without_cmd", plan_q.size(), 1);
        end else begin
          p = plan_q.pop_front();
          c = req_q.pop_front();
          chk("req_op", bus.apu_op_o, c.op);
          chk("req_operands", bus.apu_operands_o, c.operands);
          chk("req_flags", bus.apu_flags_o, c.flags);
          repeat (p.gnt_dly) begin
            @(negedge clk);
            chk("req_held", bus.apu_req, 1);
            chk("req_operands_stable", bus.apu_operands_o, c.operands);
          end
          bus.apu_gnt     = 1'b1;
          bus.apu_rvalid  = (p.rv_dly == 0);
          bus.apu_result  = (p.rv_dly == 0) ? p.res : $urandom;
          bus.apu_flags_i = (p.rv_dly == 0) ? p.rfl : 5'($urandom);
          @(negedge clk);
          bus.apu_gnt    = 1'b0;
          bus.apu_rvalid = 1'b0;
          bus.apu_result = $urandom;
          chk("req_drop_after_gnt", bus.apu_req, 0);
          if (p.rv_dly > 0 && p.rv_dly <= TMO + 4) begin
            repeat (p.rv_dly - 1) @(negedge clk);
            bus.apu_rvalid  = 1'b1;
            bus.apu_result  = p.res;
            bus.apu_flags_i = p.rfl;
            @(negedge clk);
            bus.apu_rvalid  = 1'b0;
            bus.apu_result  = $urandom;
          end
        end
      end
    end
  end

  // ---------------- response monitor ----------------
  logic             hold_v = 1'b0;
  logic [EXP_W-1:0] held;

  always @(negedge clk) begin
    logic [EXP_W-1:0] act;
    if (reset) begin
      hold_v = 1'b0;
    end else begin
      act = {bus.rsp_timeout, bus.rsp_rd, bus.rsp_flags, bus.rsp_result};
      if (hold_v) begin
        chk("rsp_valid_held", bus.rsp_valid, 1);
        chk("rsp_stable", act, held);
        chk("req_low_in_resp", bus.apu_req, 0);
      end
      if (bus.rsp_valid && bus.rsp_ready) begin
        n_rsp++;
        if (exp_q.size() == 0) chk("rsp_without_cmd", exp_q.size(), 1);
        else chk("rsp", act, exp_q.pop_front());
      end
      hold_v = bus.rsp_valid && !bus.rsp_ready;
      held   = act;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    apu_cmd_t c;
    plan_t    p;
    int       w;
    int       base;
    int       k;

    bus.cmd_valid    = 1'b0;
    bus.cmd_op       = '0;
    bus.cmd_operands = '0;
    bus.cmd_flags    = '0;
    bus.cmd_rd       = '0;
    reset            = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_apu_req", bus.apu_req, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_cmd_ready", bus.cmd_ready, 1);
    chk("rst_rsp_result", bus.rsp_result, 0);
    chk("rst_operands", bus.apu_operands_o, 0);
    chk("rst_state", state, IDLE);
    reset = 1'b0;
    @(negedge clk);

    // Minimum latency: grant and result in the first request cycle.
    rdy_mode = 1;
    c = '{op: 6'h1, operands: {32'd0, 32'd0, 32'd17}, flags: 15'h0, rd: 5'd5};
    p = '{gnt_dly: 0, rv_dly: 0, res: 32'd16, rfl: 5'd0};
    push_cmd(c, p, w);
    chk("t1_lat_c1", bus.rsp_valid, 0);
    @(negedge clk);
    chk("t1_lat_c2", bus.rsp_valid, 0);
    @(negedge clk);
    chk("t1_lat_c3", bus.rsp_valid, 1);
    chk("t1_result", bus.rsp_result, 16);
    chk("t1_rd", bus.rsp_rd, 5);
    chk("t1_timeout", bus.rsp_timeout, 0);
    drain();

    // Grant held off for 4 cycles, result 2 cycles after grant.
    base = n_rsp;
    push_cmd(rand_cmd(5'd2), mk_plan(4, 2), w);
    drain();
    repeat (4) @(negedge clk);
    chk("t2_one_rsp", n_rsp - base, 1);

    // Writeback stalls: responses back up, FIFO fills, no new request issues.
    rdy_mode = 0;
    push_cmd(rand_cmd(5'd0), mk_plan(0, 1), w);
    wait_rsp_valid("t6_rsp_present");
    push_cmd(rand_cmd(5'd1), mk_plan(1, 0), w);
    push_cmd(rand_cmd(5'd2), mk_plan(0, 3), w);
    chk("t3_ready_low", bus.cmd_ready, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t6_req_low", bus.apu_req, 0);
    end
    chk("t6_busy", bus.busy, 1);
    fork
      push_cmd(rand_cmd(5'd3), mk_plan(2, 1), w);
      begin
        repeat (2) @(negedge clk);
        rdy_mode = 1;
      end
    join
    chk("t3_push3_waited", (w >= 2), 1);
    drain();

    // Timeout boundary: result on the 8th wait cycle wins, 9th is too late.
    push_cmd(rand_cmd(5'd4), mk_plan(0, 8), w);
    drain();
    push_cmd(rand_cmd(5'd6), mk_plan(0, 9), w);
    drain();
    push_cmd(rand_cmd(5'd7), mk_plan(1, 10), w);
    wait_rsp_valid("t4_rsp_present");
    chk("t4_timeout_flag", bus.rsp_timeout, 1);
    chk("t4_timeout_result", bus.rsp_result, 0);
    push_cmd(rand_cmd(5'd8), mk_plan(0, 1), w);
    drain();

    // Reset during WAIT_RVALID with one command queued.
    push_cmd(rand_cmd(5'd9), mk_plan(0, 100), w);
    push_cmd(rand_cmd(5'd10), mk_plan(0, 0), w);
    k = 0;
    while (state != WAIT_RVALID && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("t5_in_wait", state, WAIT_RVALID);
    chk("t5_busy_before", bus.busy, 1);
    reset = 1'b1;
    #1;
    chk("t5_rst_req", bus.apu_req, 0);
    chk("t5_rst_rsp_valid", bus.rsp_valid, 0);
    chk("t5_rst_busy", bus.busy, 0);
    chk("t5_rst_cmd_ready", bus.cmd_ready, 1);
    exp_q.delete();
    req_q.delete();
    plan_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t5_post_req", bus.apu_req, 0);
      chk("t5_post_rsp", bus.rsp_valid, 0);
    end
    chk("t5_post_busy", bus.busy, 0);

    // Randomized traffic with random writeback back-pressure.
    rdy_mode = 2;
    for (int i = 0; i < 40; i++) begin
      push_cmd(rand_cmd(5'(i)), mk_plan($urandom_range(0, 3), $urandom_range(0, 11)), w);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    drain();
    rdy_mode = 1;
    repeat (4) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
